// File: rtl/uart_boot_loader.sv
// rtl/uart_boot_loader.sv - framed UART image loader that fills instruction memory and releases the core
module uart_boot_loader #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         ADDR_WIDTH     = 10,
    parameter int         TIMEOUT_CYCLES = 2_700_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_data_valid,
    output logic                  rx_data_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_rst_n,
    output logic                  load_done,
    output logic                  load_error,
    output logic [1:0]            err_code
);

    localparam int              TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0]     MAX_LEN  = 17'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERROR
    } state_t;

    state_t        state, next_state;
    logic [1:0]    next_err;
    logic [15:0]   len;
    logic [15:0]   len_new;
    logic [15:0]   word_cnt;
    logic [15:0]   word_cnt_inc;
    logic [23:0]   word;
    logic [1:0]    idx;
    logic [7:0]    sum;
    logic [TW-1:0] tmo;
    logic          accept;
    logic          timed;
    logic          tmo_hit;
    logic          is_sync;

    assign accept       = rx_data_valid && rx_data_ready;
    assign is_sync      = (rx_data == SYNC_BYTE);
    assign len_new      = {rx_data, len[7:0]};
    assign word_cnt_inc = word_cnt + 16'd1;
    assign timed        = (state == S_LEN0) || (state == S_LEN1) ||
                          (state == S_DATA) || (state == S_CSUM);
    // A byte arriving on the expiry cycle keeps the frame alive.
    assign tmo_hit      = timed && !accept && (tmo == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        next_err   = err_code;
        case (state)
            S_IDLE: begin
                if (accept && is_sync) next_state = S_LEN0;
            end
            S_LEN0: begin
                if (accept) next_state = S_LEN1;
            end
            S_LEN1: begin
                if (accept) begin
                    if ({1'b0, len_new} > MAX_LEN) begin
                        next_state = S_ERROR;
                        next_err   = 2'd2;
                    end else if (len_new == 16'd0) begin
                        next_state = S_CSUM;
                    end else begin
                        next_state = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept && idx == 2'd3) next_state = S_WRITE;
            end
            S_WRITE: begin
                next_state = (word_cnt_inc == len) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (accept) begin
                    if (rx_data == sum) begin
                        next_state = S_DONE;
                    end else begin
                        next_state = S_ERROR;
                        next_err   = 2'd3;
                    end
                end
            end
            S_DONE, S_ERROR: begin
                if (accept && is_sync) begin
                    next_state = S_LEN0;
                    next_err   = 2'd0;
                end
            end
            default: next_state = S_IDLE;
        endcase
        if (tmo_hit) begin
            next_state = S_ERROR;
            next_err   = 2'd1;
        end
    end

    // Status outputs are registered from next_state so they change in the cycle the state does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_ready <= 1'b0;
            mem_we        <= 1'b0;
            cpu_rst_n     <= 1'b0;
            load_done     <= 1'b0;
            load_error    <= 1'b0;
            err_code      <= 2'd0;
        end else begin
            rx_data_ready <= (next_state != S_WRITE);
            mem_we        <= (next_state == S_WRITE);
            cpu_rst_n     <= (next_state == S_DONE);
            load_done     <= (next_state == S_DONE);
            load_error    <= (next_state == S_ERROR);
            err_code      <= next_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len       <= 16'd0;
            word_cnt  <= 16'd0;
            word      <= 24'd0;
            idx       <= 2'd0;
            sum       <= 8'd0;
            tmo       <= '0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
        end else begin
            if (!timed || accept) begin
                tmo <= '0;
            end else begin
                tmo <= tmo + TW'(1);
            end

            if (next_state == S_LEN0 && state != S_LEN0) begin
                sum      <= 8'd0;
                word_cnt <= 16'd0;
                idx      <= 2'd0;
            end

            case (state)
                S_LEN0: if (accept) len[7:0]  <= rx_data;
                S_LEN1: if (accept) len[15:8] <= rx_data;
                S_DATA: begin
                    if (accept) begin
                        sum <= sum + rx_data;
                        idx <= idx + 2'd1;
                        case (idx)
                            2'd0: word[7:0]   <= rx_data;
                            2'd1: word[15:8]  <= rx_data;
                            2'd2: word[23:16] <= rx_data;
                            default: begin
                                mem_wdata <= {rx_data, word};
                                mem_addr  <= word_cnt[ADDR_WIDTH-1:0];
                            end
                        endcase
                    end
                end
                S_WRITE: word_cnt <= word_cnt_inc;
                default: ;
            endcase
        end
    end

endmodule
